shake_squeeze_unpacker: RTL and testbench
=========================================

// Module: shake_squeeze_unpacker
// PURPOSE
//  Sits directly downstream of keccak. Consumes the w-bit squeezed words from the dump stage and
//  buffers them in a small word FIFO. Serializes them into a byte stream with valid/ready and a
//  last flag, truncating to the requested output length. Drives the active-low ready_in of keccak.
// PARAMETERS
//  FIFO_DEPTH  4   word FIFO depth; power of 2, >=2
//  LEN_W       32  width of out_len (bytes)
//  (word width is keccak_pkg::w and must be a multiple of 8; tests use w=64)
// PORTS
//  clk          in   1      clock
//  rst          in   1      synchronous reset, active-low
//  start        in   1      1-cycle pulse; latches out_len; ignored unless state==IDLE
//  out_len      in   LEN_W  requested output length in bytes
//  busy         out  1      high in RUN and DONE
//  done         out  1      1-cycle pulse after the final byte is accepted (or for out_len==0)
//  kc_valid     in   1      keccak valid_out (active-high)
//  kc_data      in   w      keccak data_out
//  kc_ready_n   out  1      to keccak ready_in; active-low, 0 = word accepted this cycle
//  m_valid      out  1      byte stream valid
//  m_data       out  8      byte stream data
//  m_last       out  1      high with the final byte of the request
//  m_ready      in   1      byte stream ready
// BEHAVIOUR
//  Reset (rst==0 on a clk edge): state=IDLE; FIFO emptied; counters cleared; kc_ready_n=1;
//   m_valid=0, m_data=0, m_last=0, done=0, busy=0. Reset mid-request drops all buffered data.
//  Word handshake: kc_valid && !kc_ready_n. kc_ready_n=0 only when state==RUN, FIFO not full,
//   and words_taken < words_needed, where words_needed = ceil(out_len*8/w), computed in LEN_W+1 bits.
//   Surplus words from keccak are never accepted.
//  Byte handshake: m_valid && m_ready. m_data, m_valid and m_last are registered. m_data is held
//   stable while m_valid && !m_ready.
//  Lane order: byte k of a word = kc_data[8k+7:8k], emitted from k=0 upward (little-endian,
//   matching the SHAKE byte order).
//  Latency: a word accepted in cycle N gives its first byte on m_valid in cycle N+2 when the
//   output stage is idle.
//  Throughput: 1 byte/cycle with m_ready held high, with no bubble at word boundaries while the
//   FIFO is non-empty. After the last lane of a word is accepted, the next FIFO word loads in the
//   same cycle.
//  Truncation: bytes_left counts down per byte handshake. m_last=1 when bytes_left==1. The
//   remaining lanes of the final word are discarded, and that FIFO entry is popped.
//  FSM:
//   IDLE: start && out_len!=0 -> RUN. start && out_len==0 -> DONE; no words taken, no beats.
//   RUN:  byte handshake with m_last -> DONE.
//   DONE: done=1 for this cycle only -> IDLE. kc_ready_n=1 and m_valid=0 in DONE.
//  Simultaneous events:
//   - A FIFO push and pop in the same cycle while full: the push is not allowed, because
//     kc_ready_n was already 1 when full (no combinational ready-through).
//   - A push and pop in the same cycle while not full are both performed; occupancy is unchanged.
//   - start in RUN or DONE is ignored.
//  Counters saturate-free: words_taken <= words_needed by construction. out_len max 2^LEN_W-1 is
//   legal.
// STRUCTURE
//  keccak_pkg additions: BYTES_PER_WORD = w/8; LANE_IDX_W = $clog2(w/8);
//   typedef enum logic [1:0] {SQ_IDLE, SQ_RUN, SQ_DONE} squeeze_state_t.
//  Sub-module shake_word_fifo: sync FIFO (w bits x FIFO_DEPTH) with push/pop/full/empty and
//   show-ahead read data, same clk/rst.
//  Top level contains the FSM, the words/bytes counters and the lane-select shift register.
// TESTING (w=64, FIFO_DEPTH=4)
//  1. out_len=32, m_ready=1, kc_valid=1 with 4 distinct words -> exactly 4 word handshakes and 32
//     bytes in little-endian lane order. m_last on byte 32 only, then done one cycle later, then
//     kc_ready_n=1.
//  2. out_len=13 -> 2 word handshakes, 13 bytes (8 + 5). m_last on byte 13. Bytes 14-16 are never
//     emitted. A third offered word is never accepted.
//  3. m_ready=0 for 40 cycles while kc_valid=1 -> exactly 4 words accepted, then kc_ready_n stays
//     1. m_data is held stable throughout. Releasing m_ready drains all bytes with no bubbles.
//  4. Random m_ready/kc_valid toggling, out_len=168 -> output bytes equal the reference byte
//     array, and m_last/done are each seen once.
//  5. start with out_len=0 -> done pulse 1 cycle later, zero word and byte handshakes. start
//     during RUN is ignored.
//  6. rst=0 mid-request after 2 words and 5 bytes -> all outputs at reset values next cycle. A new
//     request with out_len=8 then completes with correct data.

Source files
------------

// File: rtl/keccak_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keccak_pkg
// Description : Shared word-geometry constants and the squeeze-unpacker state
//               encoding for the keccak output path.
//               W              keccak lane/word width in bits (multiple of 8, >= 16)
//               BYTES_PER_WORD bytes carried by one squeezed word
//               LANE_IDX_W     width of a byte-lane index within a word
// Revision    : 1.0 - initial release
// ============================================================================
package keccak_pkg;

    localparam int W              = 64;
    localparam int BYTES_PER_WORD = W / 8;
    localparam int LANE_IDX_W     = $clog2(BYTES_PER_WORD);

    typedef enum logic [1:0] {
        SQ_IDLE = 2'd0,
        SQ_RUN  = 2'd1,
        SQ_DONE = 2'd2
    } squeeze_state_t;

endpackage
`default_nettype wire

// File: rtl/shake_word_fifo.sv
`default_nettype none
// ============================================================================
// Module      : shake_word_fifo
// Description : Synchronous word FIFO with show-ahead read data. The head
//               entry is always visible on pop_data while empty is low.
//               Pushes while full and pops while empty are ignored.
// Ports       : clk        clock
//               rst        synchronous reset, active-low (empties the FIFO)
//               push       write push_data this cycle
//               push_data  WIDTH-bit write data
//               pop        discard the head entry this cycle
//               pop_data   WIDTH-bit head entry (show-ahead)
//               full       no free entry
//               empty      no stored entry
// Revision    : 1.0 - initial release
// ============================================================================
module shake_word_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == (AW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign pop_data  = r_mem[r_rd_ptr];

    // Storage carries no reset; validity is tracked solely by r_count.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap on natural overflow.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/shake_squeeze_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : shake_squeeze_unpacker
// Description : Accepts W-bit squeezed words from keccak into a small word
//               FIFO and serializes them little-endian into a byte stream,
//               truncated to the requested length, with a last flag.
// Ports       : clk         clock
//               rst         synchronous reset, active-low
//               start       1-cycle request pulse, honoured only in IDLE
//               out_len     requested output length in bytes
//               busy        request in progress (RUN or DONE)
//               done        1-cycle completion pulse
//               kc_valid    keccak word valid
//               kc_data     keccak word
//               kc_ready_n  active-low word ready back to keccak
//               m_valid     byte stream valid (registered)
//               m_data      byte stream data (registered)
//               m_last      final byte of the request (registered)
//               m_ready     byte stream ready
// Revision    : 1.0 - initial release
// ============================================================================
module shake_squeeze_unpacker
    import keccak_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] out_len,
    output logic             busy,
    output logic             done,
    input  logic             kc_valid,
    input  logic [W-1:0]     kc_data,
    output logic             kc_ready_n,
    output logic             m_valid,
    output logic [7:0]       m_data,
    output logic             m_last,
    input  logic             m_ready
);

    squeeze_state_t r_state;
    squeeze_state_t w_state_nxt;

    logic [LEN_W:0]      r_words_needed;
    logic [LEN_W:0]      r_words_taken;
    logic [LEN_W-1:0]    r_bytes_to_load;
    logic [LANE_IDX_W-1:0] r_lane;
    logic                r_m_valid;
    logic                r_m_last;
    logic [7:0]          r_m_data;

    logic [LEN_W:0]      w_words_req;
    logic                w_take;
    logic                w_push;
    logic                w_pop;
    logic                w_beat;
    logic                w_load;
    logic                w_final_lane;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [W-1:0]        w_fifo_head;
    logic [7:0]          w_lane_byte;

    // ceil(out_len / BYTES_PER_WORD) in LEN_W+1 bits so the maximum length
    // cannot overflow the rounding add.
    assign w_words_req = ({1'b0, out_len} + (LEN_W+1)'(BYTES_PER_WORD - 1)) >> LANE_IDX_W;

    // Ready depends only on registered state, so a full FIFO never accepts a
    // word even if it is popped in the same cycle.
    assign w_take     = (r_state == SQ_RUN) && !w_fifo_full && (r_words_taken < r_words_needed);
    assign kc_ready_n = !w_take;
    assign w_push     = kc_valid && w_take;

    assign w_beat      = r_m_valid && m_ready;
    assign w_lane_byte = w_fifo_head[{r_lane, 3'b000} +: 8];

    // The output register refills whenever it is empty or being drained.
    // A word stays at the FIFO head until its last needed lane is copied
    // out, so the next word's lane 0 is visible in the following cycle.
    assign w_final_lane = (r_lane == LANE_IDX_W'(BYTES_PER_WORD - 1)) ||
                          (r_bytes_to_load == LEN_W'(1));
    assign w_load       = (r_state == SQ_RUN) && (!r_m_valid || w_beat) &&
                          !w_fifo_empty && (r_bytes_to_load != '0);
    assign w_pop        = w_load && w_final_lane;

    shake_word_fifo #(
        .WIDTH (W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (kc_data),
        .pop       (w_pop),
        .pop_data  (w_fifo_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= SQ_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SQ_IDLE: begin
                if (start) begin
                    w_state_nxt = (out_len == '0) ? SQ_DONE : SQ_RUN;
                end
            end
            SQ_RUN: begin
                if (w_beat && r_m_last) begin
                    w_state_nxt = SQ_DONE;
                end
            end
            SQ_DONE: begin
                w_state_nxt = SQ_IDLE;
            end
            default: begin
                w_state_nxt = SQ_IDLE;
            end
        endcase
    end

    assign busy = (r_state != SQ_IDLE);
    assign done = (r_state == SQ_DONE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_words_needed  <= '0;
            r_words_taken   <= '0;
            r_bytes_to_load <= '0;
            r_lane          <= '0;
            r_m_valid       <= 1'b0;
            r_m_last        <= 1'b0;
            r_m_data        <= 8'h00;
        end else begin
            if ((r_state == SQ_IDLE) && start) begin
                r_words_needed  <= w_words_req;
                r_words_taken   <= '0;
                r_bytes_to_load <= out_len;
                r_lane          <= '0;
            end

            if (w_push) begin
                r_words_taken <= r_words_taken + (LEN_W+1)'(1);
            end

            if (w_load) begin
                r_m_valid       <= 1'b1;
                r_m_data        <= w_lane_byte;
                r_m_last        <= (r_bytes_to_load == LEN_W'(1));
                r_bytes_to_load <= r_bytes_to_load - LEN_W'(1);
                // Truncation restarts at lane 0 too, since that word is popped.
                r_lane          <= w_final_lane ? '0 : r_lane + LANE_IDX_W'(1);
            end else if (w_beat) begin
                r_m_valid <= 1'b0;
                r_m_last  <= 1'b0;
            end
        end
    end

    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;
    assign m_last  = r_m_last;

endmodule
`default_nettype wire

// File: tb/tb_shake_squeeze_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : tb_shake_squeeze_unpacker
// Description : Scoreboard bench for shake_squeeze_unpacker (W=64, depth 4).
//               Expected bytes are queued at request time from the word
//               table; a monitor pops and compares on every byte handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shake_squeeze_unpacker;
    import keccak_pkg::*;

    localparam int LEN_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] out_len;
    logic             busy;
    logic             done;
    logic             kc_valid;
    logic [63:0]      kc_data;
    logic             kc_ready_n;
    logic             m_valid;
    logic [7:0]       m_data;
    logic             m_last;
    logic             m_ready;

    always #5 clk = ~clk;

    shake_squeeze_unpacker #(
        .FIFO_DEPTH (4),
        .LEN_W      (LEN_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .out_len    (out_len),
        .busy       (busy),
        .done       (done),
        .kc_valid   (kc_valid),
        .kc_data    (kc_data),
        .kc_ready_n (kc_ready_n),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_last     (m_last),
        .m_ready    (m_ready)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t        expq[$];
    logic [63:0] words [0:31];

    int n_cmp = 0;
    int n_bad = 0;
    int whs = 0, bhs = 0, nlast = 0, ndone = 0;
    int widx = 0;
    int wlimit = 32;
    bit took = 0, widx_clr = 0;
    bit kc_en = 0, kc_rand = 0, mr_en = 0, mr_rand = 0;
    bit prev_stall = 0;
    logic [7:0] prev_data = 8'h00;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Byte monitor / scoreboard consumer; also counts word handshakes.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                prev_stall = 0;
                took       = 0;
            end else begin
                took = kc_valid && !kc_ready_n;
                if (took) whs++;
                if (prev_stall) begin
                    chk("hold_valid", 64'(m_valid), 64'd1);
                    chk("hold_data", 64'(m_data), 64'(prev_data));
                end
                prev_stall = m_valid && !m_ready;
                prev_data  = m_data;
                if (m_valid && m_ready) begin
                    bhs++;
                    if (m_last) nlast++;
                    if (expq.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL extra_byte: got %02h with no byte outstanding", m_data);
                    end else begin
                        e = expq.pop_front();
                        chk("byte", 64'(m_data), 64'(e.data));
                        chk("last", 64'(m_last), 64'(e.last));
                    end
                end
                if (done) ndone++;
            end
        end
    endtask

    // Keccak word source and byte sink ready generator.
    task automatic driver();
        forever begin
            @(posedge clk);
            #1;
            if (took) begin
                widx++;
                took = 0;
            end
            if (widx_clr) begin
                widx     = 0;
                widx_clr = 0;
            end
            kc_data  = words[(widx < 32) ? widx : 31];
            kc_valid = kc_en && (widx < wlimit) && (!kc_rand || ($urandom_range(1, 0) == 1));
            m_ready  = mr_en && (!mr_rand || ($urandom_range(1, 0) == 1));
        end
    endtask

    task automatic fill(input int seed);
        for (int i = 0; i < 32; i++) begin
            words[i] = {(32'(seed) * 32'h9E37_79B9) ^ (32'(i) * 32'h0101_0101),
                        (32'(i) * 32'h1111_1111) + 32'h0706_0500 + 32'(seed)};
        end
        widx_clr = 1;
    endtask

    task automatic push_req(input int len);
        exp_t        e;
        logic [63:0] wd;
        for (int b = 0; b < len; b++) begin
            wd     = words[b / 8];
            e.data = wd[(b % 8) * 8 +: 8];
            e.last = (b == len - 1);
            expq.push_back(e);
        end
    endtask

    task automatic pulse_start(input int len);
        @(posedge clk);
        #1;
        out_len = LEN_W'(len);
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
    endtask

    // Follows one request until done; cycle indices are counted from 1.
    task automatic watch(input int budget, output int t_whs, output int t_mv,
                         output int t_last, output int t_done, output int gaps);
        int c  = 0;
        int nb = 0;
        t_whs = -1; t_mv = -1; t_last = -1; t_done = -1; gaps = 0;
        forever begin
            @(negedge clk);
            c++;
            if (t_whs < 0 && kc_valid && !kc_ready_n) t_whs = c;
            if (t_mv < 0 && m_valid) t_mv = c;
            if (m_valid && m_ready) begin
                nb++;
                if (m_last) t_last = c;
            end else if (nb > 0 && t_last < 0) begin
                gaps++;
            end
            if (done) begin
                t_done = c;
                break;
            end
            if (c >= budget) begin
                n_cmp++;
                n_bad++;
                $display("FAIL timeout: no done after %0d cycles, required done", c);
                break;
            end
        end
    endtask

    initial begin
        int bw, bb, bl, bd;
        int t_whs, t_mv, t_last, t_done, gaps;
        int c;

        rst = 1'b0; start = 1'b0; out_len = '0;
        kc_valid = 1'b0; kc_data = '0; m_ready = 1'b0;
        fork
            monitor();
            driver();
        join_none

        fill(1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_last", 64'(m_last), 64'd0);
        chk("rst_m_data", 64'(m_data), 64'd0);
        chk("rst_kc_ready_n", 64'(kc_ready_n), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // 1: 32 bytes, four full words, free-flowing
        kc_en = 1; mr_en = 1;
        fill(1);
        bw = whs; bb = bhs; bl = nlast; bd = ndone;
        push_req(32);
        pulse_start(32);
        watch(200, t_whs, t_mv, t_last, t_done, gaps);
        chk("t1_words", 64'(whs - bw), 64'd4);
        chk("t1_bytes", 64'(bhs - bb), 64'd32);
        chk("t1_last_cnt", 64'(nlast - bl), 64'd1);
        chk("t1_latency", 64'(t_mv - t_whs), 64'd2);
        chk("t1_done_after_last", 64'(t_done - t_last), 64'd1);
        chk("t1_gaps", 64'(gaps), 64'd0);
        chk("t1_ready_n_in_done", 64'(kc_ready_n), 64'd1);
        chk("t1_m_valid_in_done", 64'(m_valid), 64'd0);
        @(negedge clk);
        chk("t1_done_pulse", 64'(done), 64'd0);
        chk("t1_busy_idle", 64'(busy), 64'd0);
        chk("t1_ready_n_idle", 64'(kc_ready_n), 64'd1);
        chk("t1_done_cnt", 64'(ndone - bd), 64'd1);
        chk("t1_queue_empty", 64'(expq.size()), 64'd0);

        // 2: 13 bytes, truncated second word, third word never taken
        fill(2);
        bw = whs; bb = bhs; bl = nlast;
        push_req(13);
        pulse_start(13);
        watch(200, t_whs, t_mv, t_last, t_done, gaps);
        repeat (10) @(negedge clk);
        chk("t2_words", 64'(whs - bw), 64'd2);
        chk("t2_bytes", 64'(bhs - bb), 64'd13);
        chk("t2_last_cnt", 64'(nlast - bl), 64'd1);
        chk("t2_queue_empty", 64'(expq.size()), 64'd0);

        // 3: sink stalled for 40 cycles, then drained
        mr_en = 0;
        fill(3);
        bw = whs; bb = bhs;
        push_req(64);
        pulse_start(64);
        repeat (40) @(negedge clk);
        chk("t3_words_stalled", 64'(whs - bw), 64'd4);
        chk("t3_ready_n_full", 64'(kc_ready_n), 64'd1);
        chk("t3_bytes_stalled", 64'(bhs - bb), 64'd0);
        chk("t3_valid_stalled", 64'(m_valid), 64'd1);
        mr_en = 1;
        watch(400, t_whs, t_mv, t_last, t_done, gaps);
        chk("t3_gaps", 64'(gaps), 64'd0);
        chk("t3_words", 64'(whs - bw), 64'd8);
        chk("t3_bytes", 64'(bhs - bb), 64'd64);
        chk("t3_queue_empty", 64'(expq.size()), 64'd0);

        // 4: random toggling, 168 bytes = 21 words
        kc_rand = 1; mr_rand = 1;
        fill(4);
        bw = whs; bb = bhs; bl = nlast; bd = ndone;
        push_req(168);
        pulse_start(168);
        watch(3000, t_whs, t_mv, t_last, t_done, gaps);
        @(negedge clk);
        chk("t4_words", 64'(whs - bw), 64'd21);
        chk("t4_bytes", 64'(bhs - bb), 64'd168);
        chk("t4_last_cnt", 64'(nlast - bl), 64'd1);
        chk("t4_done_cnt", 64'(ndone - bd), 64'd1);
        chk("t4_queue_empty", 64'(expq.size()), 64'd0);
        kc_rand = 0; mr_rand = 0;

        // 5a: zero-length request
        fill(5);
        bw = whs; bb = bhs;
        pulse_start(0);
        watch(20, t_whs, t_mv, t_last, t_done, gaps);
        chk("t5_done_latency", 64'(t_done), 64'd1);
        chk("t5_words", 64'(whs - bw), 64'd0);
        chk("t5_bytes", 64'(bhs - bb), 64'd0);

        // 5b: second start during RUN is ignored
        fill(6);
        bw = whs; bb = bhs; bd = ndone;
        push_req(16);
        pulse_start(16);
        repeat (3) @(posedge clk);
        #1;
        out_len = LEN_W'(8);
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        watch(200, t_whs, t_mv, t_last, t_done, gaps);
        @(negedge clk);
        chk("t5_run_words", 64'(whs - bw), 64'd2);
        chk("t5_run_bytes", 64'(bhs - bb), 64'd16);
        chk("t5_run_done_cnt", 64'(ndone - bd), 64'd1);
        chk("t5_queue_empty", 64'(expq.size()), 64'd0);

        // 6: reset after 2 words and 5 bytes, then a fresh 8-byte request
        wlimit = 2;
        fill(7);
        bw = whs; bb = bhs;
        push_req(32);
        pulse_start(32);
        c = 0;
        while ((bhs - bb) < 5 && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk("t6_reached_5_bytes", 64'(bhs - bb), 64'd5);
        chk("t6_words_before_rst", 64'(whs - bw), 64'd2);
        @(posedge clk);
        #1;
        rst = 1'b0;
        expq.delete();
        @(posedge clk);
        @(negedge clk);
        chk("t6_rst_m_valid", 64'(m_valid), 64'd0);
        chk("t6_rst_m_data", 64'(m_data), 64'd0);
        chk("t6_rst_m_last", 64'(m_last), 64'd0);
        chk("t6_rst_busy", 64'(busy), 64'd0);
        chk("t6_rst_done", 64'(done), 64'd0);
        chk("t6_rst_ready_n", 64'(kc_ready_n), 64'd1);
        @(posedge clk);
        #1;
        rst    = 1'b1;
        wlimit = 32;
        fill(8);
        bw = whs; bb = bhs;
        push_req(8);
        pulse_start(8);
        watch(100, t_whs, t_mv, t_last, t_done, gaps);
        @(negedge clk);
        chk("t6_new_words", 64'(whs - bw), 64'd1);
        chk("t6_new_bytes", 64'(bhs - bb), 64'd8);
        chk("t6_queue_empty", 64'(expq.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
